// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for the registered immediate-generation stage.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_inst;
    logic [2:0]      i_imm_sel;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_imm;
    logic [31:0]     o_inst;
    logic            o_illegal;

    modport master (
        output i_flush, i_valid, i_inst, i_imm_sel, i_ready,
        input  o_ready, o_valid, o_imm, o_inst, o_illegal
    );

    modport slave (
        input  i_flush, i_valid, i_inst, i_imm_sel, i_ready,
        output o_ready, o_valid, o_imm, o_inst, o_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with optional skid slot and synchronous flush.
// States: EMPTY = nothing held | ONE = output register full | TWO = output and skid full
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input logic           i_clk,
    input logic           i_reset,
    imm_gen_stage_if.slave bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_S    = 3'b001;
    localparam logic [2:0] FMT_B    = 3'b010;
    localparam logic [2:0] FMT_J    = 3'b011;
    localparam logic [2:0] FMT_U    = 3'b100;
    localparam logic [2:0] FMT_U2   = 3'b101;
    localparam logic [2:0] FMT_Z    = 3'b110;
    localparam logic [2:0] FMT_AUTO = 3'b111;

    logic [1:0]      state_q, state_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] out_imm_q, skid_imm_q;
    logic [31:0]     out_inst_q, skid_inst_q;
    logic            out_ill_q, skid_ill_q;

    logic [2:0]      fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;
    logic            in_fire, out_fire;
    logic            load_out, load_skid, shift_skid;
    logic            sgn;

    assign sgn = bus.i_inst[31];

    always_comb begin
        fmt     = bus.i_imm_sel;
        dec_ill = 1'b0;
        if (bus.i_imm_sel == FMT_AUTO) begin
            case (bus.i_inst[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
                7'b0100011:                         fmt = FMT_S;
                7'b1100011:                         fmt = FMT_B;
                7'b1101111:                         fmt = FMT_J;
                7'b0110111, 7'b0010111:             fmt = FMT_U;
                7'b1110011: fmt = bus.i_inst[14] ? FMT_Z : FMT_I;
                default: begin
                    fmt     = FMT_AUTO;
                    dec_ill = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        case (fmt)
            FMT_I:         dec_imm = {{(XLEN-11){sgn}}, bus.i_inst[30:20]};
            FMT_S:         dec_imm = {{(XLEN-11){sgn}}, bus.i_inst[30:25], bus.i_inst[11:7]};
            FMT_B:         dec_imm = {{(XLEN-12){sgn}}, bus.i_inst[7], bus.i_inst[30:25],
                                      bus.i_inst[11:8], 1'b0};
            FMT_J:         dec_imm = {{(XLEN-20){sgn}}, bus.i_inst[19:12], bus.i_inst[20],
                                      bus.i_inst[30:21], 1'b0};
            FMT_U, FMT_U2: dec_imm = {{(XLEN-31){sgn}}, bus.i_inst[30:12], 12'b0};
            FMT_Z:         dec_imm = {{(XLEN-5){1'b0}}, bus.i_inst[19:15]};
            default:       dec_imm = '0;
        endcase
    end

    assign bus.o_valid   = (state_q != ST_EMPTY);
    // Without the skid slot, readiness must see downstream this cycle to keep full throughput.
    assign bus.o_ready   = SKID ? ready_q : (!bus.o_valid || bus.i_ready);
    assign bus.o_imm     = out_imm_q;
    assign bus.o_inst    = out_inst_q;
    assign bus.o_illegal = out_ill_q;

    assign in_fire  = bus.i_valid && bus.o_ready;
    assign out_fire = bus.o_valid && bus.i_ready;

    always_comb begin
        state_d    = state_q;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        if (bus.i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d  = ST_ONE;
                        load_out = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_out = 1'b1;
                    end else if (in_fire && SKID) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d    = ST_ONE;
                        shift_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_EMPTY;
            ready_q     <= 1'b1;
            out_imm_q   <= '0;
            out_inst_q  <= '0;
            out_ill_q   <= 1'b0;
            skid_imm_q  <= '0;
            skid_inst_q <= '0;
            skid_ill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            if (load_out) begin
                out_imm_q  <= dec_imm;
                out_inst_q <= bus.i_inst;
                out_ill_q  <= dec_ill;
            end else if (shift_skid) begin
                out_imm_q  <= skid_imm_q;
                out_inst_q <= skid_inst_q;
                out_ill_q  <= skid_ill_q;
            end
            if (load_skid) begin
                skid_imm_q  <= dec_imm;
                skid_inst_q <= bus.i_inst;
                skid_ill_q  <= dec_ill;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: XLEN=32 skid, XLEN=64 skid and XLEN=32 single-register instances share stimulus.
module tb_imm_gen_stage;
    logic        clk;
    logic        rst;
    logic        flush, valid, rdy;
    logic [31:0] inst;
    logic [2:0]  sel;
    int          checks;
    int          errors;

    imm_gen_stage_if #(.XLEN(32)) if_a ();
    imm_gen_stage_if #(.XLEN(64)) if_b ();
    imm_gen_stage_if #(.XLEN(32)) if_c ();

    assign if_a.i_flush = flush;  assign if_b.i_flush = flush;  assign if_c.i_flush = flush;
    assign if_a.i_valid = valid;  assign if_b.i_valid = valid;  assign if_c.i_valid = valid;
    assign if_a.i_ready = rdy;    assign if_b.i_ready = rdy;    assign if_c.i_ready = rdy;
    assign if_a.i_inst  = inst;   assign if_b.i_inst  = inst;   assign if_c.i_inst  = inst;
    assign if_a.i_imm_sel = sel;  assign if_b.i_imm_sel = sel;  assign if_c.i_imm_sel = sel;

    imm_gen_stage #(.XLEN(32), .SKID(1'b1)) dut_a (.i_clk(clk), .i_reset(rst), .bus(if_a.slave));
    imm_gen_stage #(.XLEN(64), .SKID(1'b1)) dut_b (.i_clk(clk), .i_reset(rst), .bus(if_b.slave));
    imm_gen_stage #(.XLEN(32), .SKID(1'b0)) dut_c (.i_clk(clk), .i_reset(rst), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy = 1'b1; inst = '0; sel = '0;
        #12;
        chk("rst_valid_a", 64'(if_a.o_valid), 64'd0);
        chk("rst_valid_b", 64'(if_b.o_valid), 64'd0);
        chk("rst_imm_a", 64'(if_a.o_imm), 64'd0);
        chk("rst_inst_a", 64'(if_a.o_inst), 64'd0);
        chk("rst_ill_a", 64'(if_a.o_illegal), 64'd0);
        chk("rst_ready_a", 64'(if_a.o_ready), 64'd1);
        rst = 1'b0;
        cyc();

        // explicit I, sign-extended
        valid = 1'b1; inst = 32'hFFF00093; sel = 3'b000;
        cyc();
        chk("i_valid_a", 64'(if_a.o_valid), 64'd1);
        chk("i_imm_a", 64'(if_a.o_imm), 64'hFFFFFFFF);
        chk("i_imm_b", if_b.o_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("i_imm_c", 64'(if_c.o_imm), 64'hFFFFFFFF);
        chk("i_ill_a", 64'(if_a.o_illegal), 64'd0);
        chk("i_inst_a", 64'(if_a.o_inst), 64'hFFF00093);

        sel = 3'b111; inst = 32'hFE000EE3;
        cyc();
        chk("auto_b_a", 64'(if_a.o_imm), 64'hFFFFFFFC);
        chk("auto_b_b", if_b.o_imm, 64'hFFFFFFFFFFFFFFFC);
        inst = 32'h008000EF;
        cyc();
        chk("auto_j_a", 64'(if_a.o_imm), 64'h8);
        chk("auto_j_c", 64'(if_c.o_imm), 64'h8);
        inst = 32'h000FD073;
        cyc();
        chk("auto_z_a", 64'(if_a.o_imm), 64'h1F);
        chk("auto_z_ill", 64'(if_a.o_illegal), 64'd0);
        inst = 32'h0000007F;
        cyc();
        chk("auto_bad_imm", 64'(if_a.o_imm), 64'd0);
        chk("auto_bad_ill", 64'(if_a.o_illegal), 64'd1);
        chk("auto_bad_ill_b", 64'(if_b.o_illegal), 64'd1);
        inst = 32'h800000B7;
        cyc();
        chk("auto_lui_a", 64'(if_a.o_imm), 64'h80000000);
        chk("auto_lui_b", if_b.o_imm, 64'hFFFFFFFF80000000);
        inst = 32'h80002003;
        cyc();
        chk("auto_load_a", 64'(if_a.o_imm), 64'hFFFFF800);
        inst = 32'h30001073;
        cyc();
        chk("auto_csr_i_a", 64'(if_a.o_imm), 64'h300);
        sel = 3'b001; inst = 32'hFE112E23;
        cyc();
        chk("s_imm_a", 64'(if_a.o_imm), 64'hFFFFFFFC);
        sel = 3'b101; inst = 32'h12345017;
        cyc();
        chk("u_imm_a", 64'(if_a.o_imm), 64'h12345000);
        sel = 3'b110; inst = 32'hFFFFFFFF;
        cyc();
        chk("z_imm_a", 64'(if_a.o_imm), 64'h1F);
        chk("z_imm_b", if_b.o_imm, 64'h1F);
        chk("z_ill_a", 64'(if_a.o_illegal), 64'd0);
        valid = 1'b0;
        cyc();
        chk("drain_valid_a", 64'(if_a.o_valid), 64'd0);
        chk("drain_valid_c", 64'(if_c.o_valid), 64'd0);

        // backpressure: A, B, C with downstream stalled
        sel = 3'b000; rdy = 1'b0; valid = 1'b1; inst = 32'hFFF00093;
        cyc();
        chk("bp_a_valid", 64'(if_a.o_valid), 64'd1);
        chk("bp_a_ready1", 64'(if_a.o_ready), 64'd1);
        inst = 32'h00100093;
        cyc();
        chk("bp_a_ready2", 64'(if_a.o_ready), 64'd0);
        chk("bp_a_hold1", 64'(if_a.o_imm), 64'hFFFFFFFF);
        inst = 32'h00200093;
        cyc();
        chk("bp_a_ready3", 64'(if_a.o_ready), 64'd0);
        chk("bp_a_hold2", 64'(if_a.o_inst), 64'hFFF00093);
        cyc();
        chk("bp_a_hold3", 64'(if_a.o_imm), 64'hFFFFFFFF);
        chk("bp_c_ready", 64'(if_c.o_ready), 64'd0);
        chk("bp_c_hold", 64'(if_c.o_imm), 64'hFFFFFFFF);
        rdy = 1'b1;
        #1;
        chk("bp_a_ready_pre", 64'(if_a.o_ready), 64'd0);
        chk("bp_c_ready_comb", 64'(if_c.o_ready), 64'd1);
        cyc();
        chk("bp_out_b", 64'(if_a.o_imm), 64'h1);
        chk("bp_out_b_valid", 64'(if_a.o_valid), 64'd1);
        chk("bp_c_reload", 64'(if_c.o_imm), 64'h2);
        cyc();
        chk("bp_out_c", 64'(if_a.o_imm), 64'h2);
        chk("bp_out_c_inst", 64'(if_a.o_inst), 64'h00200093);
        valid = 1'b0;
        cyc();
        chk("bp_empty_a", 64'(if_a.o_valid), 64'd0);
        chk("bp_empty_c", 64'(if_c.o_valid), 64'd0);

        // flush while two entries are held, input offered in the same cycle
        rdy = 1'b0; valid = 1'b1; inst = 32'hFFF00093;
        cyc();
        inst = 32'h00100093;
        cyc();
        chk("fl_two_ready", 64'(if_a.o_ready), 64'd0);
        flush = 1'b1; inst = 32'h00200093;
        cyc();
        flush = 1'b0; valid = 1'b0;
        chk("fl_valid_a", 64'(if_a.o_valid), 64'd0);
        chk("fl_ready_a", 64'(if_a.o_ready), 64'd1);
        chk("fl_valid_c", 64'(if_c.o_valid), 64'd0);
        rdy = 1'b1;
        cyc();
        chk("fl_nothing_a", 64'(if_a.o_valid), 64'd0);
        // flush discards an input that is accepted in the flush cycle
        valid = 1'b1; inst = 32'hFFF00093;
        cyc();
        flush = 1'b1; inst = 32'h00100093;
        cyc();
        flush = 1'b0; valid = 1'b0;
        chk("fl_in_a", 64'(if_a.o_valid), 64'd0);
        chk("fl_in_c", 64'(if_c.o_valid), 64'd0);
        cyc();
        chk("fl_in_a2", 64'(if_a.o_valid), 64'd0);

        // async reset mid-cycle with one entry held
        rdy = 1'b0; valid = 1'b1; inst = 32'h00100093;
        cyc();
        valid = 1'b0;
        chk("ar_pre_valid", 64'(if_a.o_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid_a", 64'(if_a.o_valid), 64'd0);
        chk("ar_valid_b", 64'(if_b.o_valid), 64'd0);
        chk("ar_imm_a", 64'(if_a.o_imm), 64'd0);
        rst = 1'b0;
        cyc();
        rdy = 1'b1; valid = 1'b1; inst = 32'h00300093;
        #1;
        chk("ar_post_empty", 64'(if_a.o_valid), 64'd0);
        cyc();
        valid = 1'b0;
        chk("ar_first_valid", 64'(if_a.o_valid), 64'd1);
        chk("ar_first_imm", 64'(if_a.o_imm), 64'h3);
        cyc();
        chk("ar_final_empty", 64'(if_a.o_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered immediate-generation stage for the decode pipeline, replacing the purely combinational immediate generator. It accepts an instruction and a format select over a valid/ready handshake and produces the XLEN-wide sign- or zero-extended immediate one cycle later. It also passes the instruction through and flags undecodable opcodes. It adds CSR zimm support, an opcode-driven AUTO mode, a skid buffer for backpressure, and a synchronous flush.

Parameters:
XLEN, 32, immediate/output width; legal values 32 or 64.
SKID, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single register with o_ready = ~o_valid | i_ready.

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_flush  input  1  synchronous flush; drops all held entries and any input accepted this cycle
i_valid  input  1  upstream instruction valid
o_ready  output  1  stage can accept input
i_inst  input  32  instruction word
i_imm_sel  input  3  format select (see Behaviour)
o_valid  output  1  output entry valid
i_ready  input  1  downstream accepts output
o_imm  output  XLEN  generated immediate
o_inst  output  32  instruction passthrough
o_illegal  output  1  AUTO mode found no immediate format for the opcode

Behaviour:
- Reset (async, i_reset=1): state EMPTY; o_valid=0, o_imm=0, o_inst=0, o_illegal=0. o_ready=1 for SKID=1 once the stage is in EMPTY.
- Formats. The sign bit is i_inst[31]; all sign-extended results extend to XLEN.
  - 000 I: inst[31:20], sign-extended.
  - 001 S: {inst[31:25], inst[11:7]}, sign-extended.
  - 010 B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - 011 J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
  - 100 and 101 U (LUI/AUIPC): {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 110 Z: zero-extended inst[19:15] (CSR immediate forms).
  - 111 AUTO: format chosen from opcode inst[6:0]:
    - 0010011, 0000011, 1100111 -> I
    - 0100011 -> S
    - 1100011 -> B
    - 1101111 -> J
    - 0110111, 0010111 -> U
    - 1110011 -> Z if inst[14]=1, else I
    - any other opcode -> o_imm=0 and o_illegal=1
  - Explicit selects (000-110) always give o_illegal=0.
- Handshake:
  - Input transfers when i_valid && o_ready.
  - Output transfers when o_valid && i_ready.
  - Latency is 1 cycle: an entry accepted at edge N is visible on o_* after edge N.
  - While o_valid && !i_ready, o_imm, o_inst and o_illegal hold stable.
  - Entries leave in acceptance order, with no loss and no duplication.
- State machine for SKID=1 (o_ready = state != TWO, driven from a register):
  - EMPTY: on input -> ONE.
  - ONE: input without output -> TWO (new entry goes to the skid slot). Input with output -> ONE (output register reloads). Output without input -> EMPTY.
  - TWO: on output -> ONE (skid entry moves to the output register). Input cannot arrive because o_ready=0.
- SKID=0: single output register. Simultaneous output and input reloads the register in the same cycle, giving full throughput.
- Flush:
  - i_flush=1 at edge N forces EMPTY after N: o_valid=0, o_ready=1, and any same-cycle input is discarded.
  - Flush takes priority over all other events.
  - o_imm, o_inst and o_illegal are don't-care while o_valid=0; implementations hold their last value.
- Reset asserted mid-transfer clears all state immediately, with no output handshake.
- XLEN values other than 32/64 are rejected by an elaboration-time check.

Test Plan:
1. I via explicit select, XLEN=32: i_inst=0xFFF00093, i_imm_sel=000 -> one cycle later o_valid=1, o_imm=0xFFFFFFFF, o_illegal=0.
2. AUTO decode across formats, XLEN=32:
   - 0xFE000EE3 (beq -4) -> o_imm=0xFFFFFFFC.
   - 0x008000EF (jal x1,8) -> 0x00000008.
   - 0x000FD073 (csrrwi, zimm=31) -> 0x0000001F.
   - 0x0000007F -> o_imm=0, o_illegal=1.
3. XLEN=64, AUTO: i_inst=0x800000B7 (lui) -> o_imm=0xFFFFFFFF80000000.
4. Backpressure, SKID=1: i_ready=0, three back-to-back inputs A, B, C -> A and B accepted; o_ready=0 from the cycle after B until the first output handshake; C held upstream; o_* stable. Then i_ready=1 -> A, B, C emitted in order on consecutive cycles.
5. Flush with state TWO, plus i_valid=1 in the same cycle -> next cycle o_valid=0, o_ready=1; no entry ever emitted.
6. Async reset asserted between clock edges with state ONE -> o_valid=0 immediately. After release, first input appears with 1-cycle latency.
